// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: state encoding, register-zero constant, stall-counter width and
//          the control bundle driven onto the PC / IF/ID / ID/EX registers.
// Ports:   none (package).
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hazard_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 3;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                            pipe_freeze: 1'b0};
  localparam hazard_ctrl_t CTRL_RESET   = '{pc_write: 1'b0, if_id_write: 1'b0,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                            pipe_freeze: 1'b0};
  localparam hazard_ctrl_t CTRL_BUSY    = '{pc_write: 1'b0, if_id_write: 1'b0,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                            pipe_freeze: 1'b1};
  localparam hazard_ctrl_t CTRL_BRANCH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                            pipe_freeze: 1'b0};
  localparam hazard_ctrl_t CTRL_STALL   = '{pc_write: 1'b0, if_id_write: 1'b0,
                                            if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                            pipe_freeze: 1'b0};

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating 32-bit event counter
//
// Purpose: counts enable pulses, sticks at all-ones instead of wrapping.
// Ports:
//   i_clk    in   clock, rising edge
//   i_reset  in   synchronous, active-high; clears the count
//   i_en     in   count this cycle
//   o_count  out  current count [31:0]
module hazard_perf_cnt (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / taken-branch / memory-busy hazard controller
//
// Purpose: produces PC / IF/ID / ID/EX hold and flush controls for a 5-stage
//          MIPS pipeline. Controls are combinational from state, stall counter
//          and inputs; state, counter and perf counters are registered.
// Optional feature: HAZARD_PERF_EN - when defined, stall_count / flush_count
//          are saturating perf counters; otherwise both are tied to 0.
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   id_rs, id_rt        source registers of the instruction in ID
//   id_uses_rt          ID instruction actually reads Rt
//   ex_mem_read, ex_rt  load flag and destination of the instruction in ID/EX
//   ex_branch           ID/EX instruction is a branch
//   ex_branch_taken     branch condition true (valid with ex_branch)
//   mem_busy            data memory not ready this cycle
//   pc_write            PC load enable
//   if_id_write         IF/ID load enable
//   if_id_flush         IF/ID load bubble
//   id_ex_flush         ID/EX load bubble
//   pipe_freeze         hold ID/EX, EX/MEM, MEM/WB
//   stall_count         load-use stall cycles
//   flush_count         taken-branch flushes
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  pipe_freeze,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_USE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

  hazard_state_e    r_state;
  logic [CNT_W-1:0] r_cnt;

  hazard_state_e    w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  hazard_ctrl_t     w_ctrl;
  logic             w_lu;
  logic             w_br;
  logic             w_stall_inc;
  logic             w_flush_inc;

  // A load into $0 never produces a value anyone waits for.
  assign w_lu = ex_mem_read && (ex_rt != REG_ADDR_W'(REG_ZERO)) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign w_br = ex_branch && ex_branch_taken;

  always_comb begin
    w_ctrl      = CTRL_DEFAULT;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;

    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (mem_busy) begin
      // Whole pipe frozen: state and countdown hold, nothing is counted.
      w_ctrl = CTRL_BUSY;
    end else begin
      case (r_state)
        RUN: begin
          if (w_br) begin
            // Branch wins over load-use: the dependent instruction is squashed.
            w_ctrl      = CTRL_BRANCH;
            w_flush_inc = 1'b1;
          end else if (w_lu) begin
            w_ctrl      = CTRL_STALL;
            w_stall_inc = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
              w_state_nxt = LU_STALL;
              w_cnt_nxt   = CNT_RELOAD;
            end
          end
        end
        LU_STALL: begin
          // ID/EX holds a bubble here, so any branch indication is spurious.
          w_ctrl      = CTRL_STALL;
          w_stall_inc = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_write    = w_ctrl.pc_write;
  assign if_id_write = w_ctrl.if_id_write;
  assign if_id_flush = w_ctrl.if_id_flush;
  assign id_ex_flush = w_ctrl.id_ex_flush;
  assign pipe_freeze = w_ctrl.pipe_freeze;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_stall_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_stall_inc),
    .o_count (stall_count)
  );

  hazard_perf_cnt u_flush_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_flush_inc),
    .o_count (flush_count)
  );
`else
  logic w_unused_perf;
  assign w_unused_perf = w_stall_inc | w_flush_inc;
  assign stall_count   = 32'd0;
  assign flush_count   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vectors {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze}
  localparam logic [4:0] C_DEF  = 5'b11000;
  localparam logic [4:0] C_RST  = 5'b00110;
  localparam logic [4:0] C_LU   = 5'b00010;
  localparam logic [4:0] C_BR   = 5'b11110;
  localparam logic [4:0] C_BUSY = 5'b00001;

  logic       clk = 1'b0;
  // Index 0: LOAD_USE_CYCLES=1, index 1: LOAD_USE_CYCLES=3
  logic       reset           [2];
  logic [4:0] id_rs           [2];
  logic [4:0] id_rt           [2];
  logic       id_uses_rt      [2];
  logic       ex_mem_read     [2];
  logic [4:0] ex_rt           [2];
  logic       ex_branch       [2];
  logic       ex_branch_taken [2];
  logic       mem_busy        [2];
  logic       pc_write        [2];
  logic       if_id_write     [2];
  logic       if_id_flush     [2];
  logic       id_ex_flush     [2];
  logic       pipe_freeze     [2];
  logic [31:0] stall_count    [2];
  logic [31:0] flush_count    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1), .REG_ADDR_W(5)) u_dut1 (
    .clk(clk), .reset(reset[0]), .id_rs(id_rs[0]), .id_rt(id_rt[0]),
    .id_uses_rt(id_uses_rt[0]), .ex_mem_read(ex_mem_read[0]), .ex_rt(ex_rt[0]),
    .ex_branch(ex_branch[0]), .ex_branch_taken(ex_branch_taken[0]),
    .mem_busy(mem_busy[0]), .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]),
    .pipe_freeze(pipe_freeze[0]), .stall_count(stall_count[0]),
    .flush_count(flush_count[0])
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(3), .REG_ADDR_W(5)) u_dut3 (
    .clk(clk), .reset(reset[1]), .id_rs(id_rs[1]), .id_rt(id_rt[1]),
    .id_uses_rt(id_uses_rt[1]), .ex_mem_read(ex_mem_read[1]), .ex_rt(ex_rt[1]),
    .ex_branch(ex_branch[1]), .ex_branch_taken(ex_branch_taken[1]),
    .mem_busy(mem_busy[1]), .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]),
    .pipe_freeze(pipe_freeze[1]), .stall_count(stall_count[1]),
    .flush_count(flush_count[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl(input int k);
    return {27'd0, pc_write[k], if_id_write[k], if_id_flush[k], id_ex_flush[k], pipe_freeze[k]};
  endfunction

  function automatic logic [31:0] perf(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic idle(input int k);
    id_rs[k] = 5'd1; id_rt[k] = 5'd2; id_uses_rt[k] = 1'b1;
    ex_mem_read[k] = 1'b0; ex_rt[k] = 5'd9;
    ex_branch[k] = 1'b0; ex_branch_taken[k] = 1'b0; mem_busy[k] = 1'b0;
  endtask

  // Load-use on Rs with register 5
  task automatic set_lu(input int k);
    ex_mem_read[k] = 1'b1; ex_rt[k] = 5'd5; id_rs[k] = 5'd5;
  endtask

  // Advance one clock; return at the falling edge so inputs/outputs settle away from posedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      reset[k] = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("rst_ctrl_d1", ctrl(0), C_RST);
    chk("rst_ctrl_d3", ctrl(1), C_RST);
    tick();
    reset[0] = 1'b0; reset[1] = 1'b0;
    #1;
    chk("post_rst_d1", ctrl(0), C_DEF);
    chk("post_rst_d3", ctrl(1), C_DEF);
    chk("post_rst_stall", stall_count[0], 32'd0);
    chk("post_rst_flush", flush_count[0], 32'd0);

    // Test 1: load-use on Rs, single bubble
    set_lu(0); #1;
    chk("lu_rs", ctrl(0), C_LU);
    tick(); idle(0); #1;
    chk("lu_rs_after", ctrl(0), C_DEF);
    chk("lu_rs_cnt", stall_count[0], perf(1));

    // Load-use on Rt
    ex_mem_read[0] = 1'b1; ex_rt[0] = 5'd2; #1;
    chk("lu_rt", ctrl(0), C_LU);
    tick(); idle(0); #1;
    chk("lu_rt_cnt", stall_count[0], perf(2));

    // Test 2: load to $0, and Rt match when Rt is unused
    ex_mem_read[0] = 1'b1; ex_rt[0] = 5'd0; id_rs[0] = 5'd0; #1;
    chk("lu_zero", ctrl(0), C_DEF);
    id_rs[0] = 5'd1; ex_rt[0] = 5'd7; id_rt[0] = 5'd7; id_uses_rt[0] = 1'b0; #1;
    chk("lu_rt_unused", ctrl(0), C_DEF);
    tick(); idle(0); #1;
    chk("no_lu_cnt", stall_count[0], perf(2));

    // Test 3: taken branch together with load-use -> flush only
    set_lu(0); ex_branch[0] = 1'b1; ex_branch_taken[0] = 1'b1; #1;
    chk("br_lu", ctrl(0), C_BR);
    tick(); idle(0); #1;
    chk("br_stall_cnt", stall_count[0], perf(2));
    chk("br_flush_cnt", flush_count[0], perf(1));
    // Not-taken branch is not a hazard
    ex_branch[0] = 1'b1; #1;
    chk("br_not_taken", ctrl(0), C_DEF);
    // mem_busy outranks a taken branch
    ex_branch_taken[0] = 1'b1; mem_busy[0] = 1'b1; #1;
    chk("busy_over_br", ctrl(0), C_BUSY);
    tick(); idle(0); #1;
    chk("busy_br_flush_cnt", flush_count[0], perf(1));

    // Test 4: LOAD_USE_CYCLES=3 gives exactly three stall cycles
    set_lu(1); #1;
    chk("lu3_c1", ctrl(1), C_LU);
    tick(); idle(1);
    ex_branch[1] = 1'b1; ex_branch_taken[1] = 1'b1; #1;
    chk("lu3_c2_br_ignored", ctrl(1), C_LU);
    tick(); idle(1); #1;
    chk("lu3_c3", ctrl(1), C_LU);
    tick(); #1;
    chk("lu3_done", ctrl(1), C_DEF);
    chk("lu3_cnt", stall_count[1], perf(3));
    chk("lu3_flush_cnt", flush_count[1], perf(0));

    // Test 5: mem_busy for two cycles inside the stall
    set_lu(1); #1;
    chk("busy_c1", ctrl(1), C_LU);
    tick(); idle(1); mem_busy[1] = 1'b1; #1;
    chk("busy_b1", ctrl(1), C_BUSY);
    tick(); #1;
    chk("busy_b2", ctrl(1), C_BUSY);
    tick(); mem_busy[1] = 1'b0; #1;
    chk("busy_c2", ctrl(1), C_LU);
    tick(); #1;
    chk("busy_c3", ctrl(1), C_LU);
    tick(); #1;
    chk("busy_done", ctrl(1), C_DEF);
    chk("busy_cnt", stall_count[1], perf(6));

    // Test 6: reset in the middle of a stall
    set_lu(1); #1;
    tick(); idle(1); #1;
    chk("mid_stall", ctrl(1), C_LU);
    chk("mid_stall_cnt", stall_count[1], perf(7));
    reset[1] = 1'b1; #1;
    chk("mid_rst_ctrl", ctrl(1), C_RST);
    tick(); reset[1] = 1'b0; #1;
    chk("mid_rst_run", ctrl(1), C_DEF);
    chk("mid_rst_stall_cnt", stall_count[1], 32'd0);
    chk("mid_rst_flush_cnt", flush_count[1], 32'd0);
    tick(); #1;
    chk("mid_rst_run2", ctrl(1), C_DEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
